// File: rtl/uart_bus_slave_pkg.sv
// Shared constants and types for the UART bus slave: default bit divider,
// STATUS bit positions, register selects, FSM state enums, clock/reset bundle.
package uart_pkg;

    localparam int MAIN_CLOCK_FREQUENCY = 60_000_000;
    localparam int UART_BAUD_RATE       = 115_200;
    localparam int UART_DIV             = MAIN_CLOCK_FREQUENCY / UART_BAUD_RATE;

    localparam int IRQ_UART = 0;

    localparam int STATUS_TX_NOT_FULL  = 0;
    localparam int STATUS_RX_NOT_EMPTY = 1;
    localparam int STATUS_TX_IDLE      = 2;
    localparam int STATUS_RX_OVERRUN   = 3;
    localparam int STATUS_FRAMING_ERR  = 4;
    localparam int STATUS_LOOPBACK     = 5;

    localparam logic UART_REG_DATA   = 1'b0;
    localparam logic UART_REG_STATUS = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } UartTxState_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } UartRxState_t;

    typedef struct packed {
        logic base;
        logic rst;
    } Clock_t;

endpackage

// File: rtl/uart_bus_slave_if.sv
// CPU bus and UART pin bundles used by uart_bus_slave.
// Bus access: a cycle with read=1 or write=1 is one complete transfer; the slave
// never stalls, read data is valid in that same cycle, side effects land on the closing edge.
interface Bus_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  mask;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic [31:0] data_rd_2;
    logic        stall;
    logic [5:0]  interrupt;

    modport master (
        output address, read, write, mask, data_wr,
        input  data_rd, data_rd_2, stall, interrupt
    );
    modport slave (
        input  address, read, write, mask, data_wr,
        output data_rd, data_rd_2, stall, interrupt
    );
endinterface

interface UART_if;
    logic txd;
    logic rxd;

    modport master (output txd, input rxd);
    modport slave  (input txd, output rxd);
endinterface

// File: rtl/uart_bus_slave_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/uart_bus_slave.sv
// UART bus slave: DATA/STATUS registers, TX/RX FIFOs, 8N1 serialiser and deserialiser.
// Optional internal loopback is compiled in with UART_LOOPBACK_EN.
module uart_bus_slave
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = MAIN_CLOCK_FREQUENCY,
    parameter int BAUD       = UART_BAUD_RATE,
    parameter int FIFO_DEPTH = 16
) (
    input  Clock_t       clk,
    Bus_if.slave         bus,
    UART_if.master       uart,
    output UartTxState_t dbg_tx_state,
    output UartRxState_t dbg_rx_state
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    logic clk_base, rst;
    assign clk_base = clk.base;
    assign rst      = clk.rst;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;

    logic reg_sel, data_rd_en, status_rd_en;
    logic tx_serial, rx_line, loopback;
    logic [31:0] status;

    UartTxState_t tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;

    UartRxState_t rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;

    logic overrun_q, overrun_d, overrun_set;
    logic framing_q, framing_d, framing_set;
    logic irq_q, irq_d;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk_base), .rst(rst), .push(tx_push), .pop(tx_pop),
        .din(bus.data_wr[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk_base), .rst(rst), .push(rx_push), .pop(rx_pop),
        .din(rx_shift_q), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    assign reg_sel      = bus.address[2];
    assign data_rd_en   = bus.read && (reg_sel == UART_REG_DATA);
    assign status_rd_en = bus.read && (reg_sel == UART_REG_STATUS);
    assign tx_push      = bus.write && (reg_sel == UART_REG_DATA) && bus.mask[0];
    assign rx_pop       = data_rd_en;

`ifdef UART_LOOPBACK_EN
    logic loopback_q, loopback_d;

    always_comb begin
        loopback_d = loopback_q;
        if (bus.write && (reg_sel == UART_REG_STATUS) && bus.mask[0]) begin
            loopback_d = bus.data_wr[0];
        end
    end

    always_ff @(posedge clk_base or posedge rst) begin
        if (rst) loopback_q <= 1'b0;
        else     loopback_q <= loopback_d;
    end

    // In loopback the pin idles high so nothing leaks onto the line.
    assign loopback = loopback_q;
    assign rx_line  = loopback_q ? tx_serial : uart.rxd;
    assign uart.txd = loopback_q ? 1'b1 : tx_serial;
`else
    assign loopback = 1'b0;
    assign rx_line  = uart.rxd;
    assign uart.txd = tx_serial;
`endif

    always_comb begin
        status = '0;
        status[STATUS_TX_NOT_FULL]  = !tx_full;
        status[STATUS_RX_NOT_EMPTY] = !rx_empty;
        status[STATUS_TX_IDLE]      = tx_empty && (tx_state_q == TX_IDLE);
        status[STATUS_RX_OVERRUN]   = overrun_q;
        status[STATUS_FRAMING_ERR]  = framing_q;
        status[STATUS_LOOPBACK]     = loopback;
        bus.data_rd = '0;
        if (data_rd_en) begin
            bus.data_rd = {24'h0, rx_empty ? 8'h00 : rx_dout};
        end else if (status_rd_en) begin
            bus.data_rd = status;
        end
    end

    assign bus.stall     = 1'b0;
    assign bus.data_rd_2 = '0;
    assign bus.interrupt = {5'b0, irq_q};

    always_comb begin
        tx_serial = 1'b1;
        case (tx_state_q)
            TX_START: tx_serial = 1'b0;
            TX_DATA:  tx_serial = tx_shift_q[0];
            default:  tx_serial = 1'b1;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_dout;
                tx_cnt_d   = '0;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_state_d = TX_DATA;
            end else begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
            TX_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_idx_d   = tx_idx_q + 3'(1);
                if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
            end else begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
            TX_STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end else begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Receiver samples the synchronised line mid-bit, starting half a bit into the start bit.
    always_comb begin
        rx_meta_d   = rx_line;
        rx_sync_d   = rx_meta_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        overrun_set = 1'b0;
        framing_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 3'(1);
                if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d    = '0;
                rx_state_d  = RX_IDLE;
                rx_push     = rx_sync_q;
                overrun_set = rx_sync_q && rx_full && !rx_pop;
                framing_set = !rx_sync_q;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Reading STATUS clears the sticky flags unless a new event lands in the same cycle.
    always_comb begin
        overrun_d = overrun_q | overrun_set;
        framing_d = framing_q | framing_set;
        if (status_rd_en) begin
            overrun_d = overrun_set;
            framing_d = framing_set;
        end
        irq_d = !rx_empty;
    end

    always_ff @(posedge clk_base or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            overrun_q  <= 1'b0;
            framing_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            overrun_q  <= overrun_d;
            framing_q  <= framing_d;
            irq_q      <= irq_d;
        end
    end

    assign dbg_tx_state = tx_state_q;
    assign dbg_rx_state = rx_state_q;

    logic unused_bus;
    assign unused_bus = ^{bus.address[31:3], bus.address[1:0], bus.data_wr[31:8], bus.mask[3:1]};

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed bench for uart_bus_slave run at 16 clocks per bit; loopback steps need UART_LOOPBACK_EN.
module tb_uart_bus_slave;
    import uart_pkg::*;

    localparam int CLK_FREQ_TB = 1_600_000;
    localparam int BAUD_TB     = 100_000;
    localparam int DIV         = CLK_FREQ_TB / BAUD_TB;

    logic   clk_base = 1'b0;
    logic   rst_s    = 1'b0;
    Clock_t clk_s;
    assign clk_s = '{base: clk_base, rst: rst_s};

    Bus_if  bus ();
    UART_if uart ();
    UartTxState_t dbg_tx_state;
    UartRxState_t dbg_rx_state;

    uart_bus_slave #(.CLK_FREQ(CLK_FREQ_TB), .BAUD(BAUD_TB), .FIFO_DEPTH(16)) dut (
        .clk(clk_s), .bus(bus), .uart(uart),
        .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
    );

    always #5 clk_base = ~clk_base;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_base);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic sel, output logic [31:0] d);
        bus.address = {8'h03, 21'h0, sel, 2'b00};
        bus.read    = 1'b1;
        #1 d = bus.data_rd;
        @(negedge clk_base);
        bus.read = 1'b0;
    endtask

    task automatic bus_write(input logic sel, input logic [31:0] d, input logic [3:0] m);
        bus.address = {8'h03, 21'h0, sel, 2'b00};
        bus.data_wr = d;
        bus.mask    = m;
        bus.write   = 1'b1;
        @(negedge clk_base);
        bus.write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic sel, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(sel, d);
        check(tag, d, exp);
    endtask

    // Drives one 8N1 frame; the stop level is held stop_cycles clocks before the line returns high.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cycles);
        uart.rxd = 1'b0;
        tick(DIV);
        for (int k = 0; k < 8; k++) begin
            uart.rxd = b[k];
            tick(DIV);
        end
        uart.rxd = stop;
        tick(stop_cycles);
        uart.rxd = 1'b1;
    endtask

    // Waits for a start bit, then samples the ten bit cells at mid-bit (returns mid stop bit).
    task automatic capture_frame(output logic [9:0] f);
        int waited = 0;
        f = '0;
        while (uart.txd !== 1'b0 && waited < 400) begin
            tick(1);
            waited++;
        end
        check("tx_start_seen", {31'h0, uart.txd}, 32'h0);
        tick(DIV / 2);
        for (int k = 0; k < 10; k++) begin
            f[k] = uart.txd;
            if (k < 9) tick(DIV);
        end
    endtask

    initial begin
        logic [9:0]  frame;
        logic [31:0] d;
        int          low_cnt;

        bus.address = '0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.mask    = '0;
        bus.data_wr = '0;
        uart.rxd    = 1'b1;

        // Clock/reset
        #3 rst_s = 1'b1;
        tick(3);
        rst_s = 1'b0;
        tick(2);

        // Reset state
        check("reset_txd", {31'h0, uart.txd}, 32'h1);
        check("reset_irq", {26'h0, bus.interrupt}, 32'h0);
        check("reset_stall", {31'h0, bus.stall}, 32'h0);
        read_check("reset_status", UART_REG_STATUS, 32'h0000_0005);

        // Single TX byte 0xA5, exact frame timing
        bus_write(UART_REG_DATA, 32'h0000_00A5, 4'b0001);
        check("tx_before_start", {31'h0, uart.txd}, 32'h1);
        tick(1);
        check("tx_start_next_cycle", {31'h0, uart.txd}, 32'h0);
        capture_frame(frame);
        check("tx_frame_a5", {22'h0, frame}, {22'h0, 10'b1_1010_0101_0});
        tick(DIV / 2 - 1);
        read_check("tx_busy_last_stop_cycle", UART_REG_STATUS, 32'h0000_0001);
        read_check("tx_idle_after_frame", UART_REG_STATUS, 32'h0000_0005);

        // DATA write without mask[0] pushes nothing
        bus_write(UART_REG_DATA, 32'h0000_0099, 4'b0010);
        tick(2);
        read_check("nomask_status", UART_REG_STATUS, 32'h0000_0005);
        check("nomask_txd", {31'h0, uart.txd}, 32'h1);

        // RX frame 0x3C, interrupt timing, pop, empty read
        send_frame(8'h3C, 1'b1, 6);
        check("rx_irq_before_stop_sample", {26'h0, bus.interrupt}, 32'h0);
        tick(6);
        check("rx_irq_after_push", {26'h0, bus.interrupt}, 32'h1);
        read_check("rx_data_3c", UART_REG_DATA, 32'h0000_003C);
        tick(1);
        check("rx_irq_cleared", {26'h0, bus.interrupt}, 32'h0);
        read_check("rx_empty_read", UART_REG_DATA, 32'h0000_0000);
        tick(20);

        // 20 back-to-back writes: first 17 bytes go out, the rest are dropped
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(i * 17 + 8'h21));
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    bus_write(UART_REG_DATA, {24'h0, 8'(i * 17 + 8'h21)}, 4'b0001);
                    if (i == 0) check("burst_idle_at_push", {31'h0, uart.txd}, 32'h1);
                    if (i == 1) check("burst_start_next_cycle", {31'h0, uart.txd}, 32'h0);
                end
            end
            begin
                for (int f = 0; f < 17; f++) begin
                    logic [9:0] fr;
                    logic [7:0] b;
                    capture_frame(fr);
                    b = exp_q.pop_front();
                    check($sformatf("burst_frame_%0d", f), {22'h0, fr}, {22'h0, 1'b1, b, 1'b0});
                end
            end
        join
        tick(40);
        read_check("burst_no_extra_frame", UART_REG_STATUS, 32'h0000_0005);
        check("burst_txd_idle", {31'h0, uart.txd}, 32'h1);

        // 17 RX frames without reading: 16 kept, overrun flagged
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i * 13 + 5));
            send_frame(8'(i * 13 + 5), 1'b1, DIV);
            tick(2);
        end
        read_check("overrun_set", UART_REG_STATUS, 32'h0000_000F);
        read_check("overrun_cleared", UART_REG_STATUS, 32'h0000_0007);
        for (int i = 0; i < 16; i++) begin
            bus_read(UART_REG_DATA, d);
            check($sformatf("rx_fifo_%0d", i), d, {24'h0, exp_q.pop_front()});
        end
        read_check("rx_drained", UART_REG_STATUS, 32'h0000_0005);

        // Framing error: stop bit 0, no push
        send_frame(8'h81, 1'b0, DIV);
        tick(20);
        read_check("framing_set", UART_REG_STATUS, 32'h0000_0015);
        read_check("framing_cleared", UART_REG_STATUS, 32'h0000_0005);

        // Short low glitch rejected as a false start
        uart.rxd = 1'b0;
        tick(5);
        uart.rxd = 1'b1;
        tick(30);
        check("glitch_rx_idle", 32'(dbg_rx_state), 32'(RX_IDLE));
        read_check("glitch_status", UART_REG_STATUS, 32'h0000_0005);

        // Reset in the middle of a TX frame with both FIFOs holding data
        send_frame(8'h77, 1'b1, DIV);
        tick(4);
        bus_write(UART_REG_DATA, 32'h0000_0055, 4'b0001);
        bus_write(UART_REG_DATA, 32'h0000_0066, 4'b0001);
        bus_write(UART_REG_DATA, 32'h0000_0011, 4'b0001);
        tick(50);
        rst_s = 1'b1;
        #1;
        check("midreset_txd", {31'h0, uart.txd}, 32'h1);
        check("midreset_tx_state", 32'(dbg_tx_state), 32'(TX_IDLE));
        check("midreset_irq", {26'h0, bus.interrupt}, 32'h0);
        tick(2);
        rst_s = 1'b0;
        tick(1);
        read_check("midreset_status", UART_REG_STATUS, 32'h0000_0005);
        low_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (uart.txd !== 1'b1) low_cnt++;
            tick(1);
        end
        check("midreset_not_resumed", 32'(low_cnt), 32'h0);

`ifdef UART_LOOPBACK_EN
        // Loopback: byte returns through RX while the pin stays high
        bus_write(UART_REG_STATUS, 32'h0000_0001, 4'b0001);
        read_check("loopback_status", UART_REG_STATUS, 32'h0000_0025);
        bus_write(UART_REG_DATA, 32'h0000_005A, 4'b0001);
        low_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (uart.txd !== 1'b1) low_cnt++;
            tick(1);
        end
        check("loopback_pin_high", 32'(low_cnt), 32'h0);
        read_check("loopback_data", UART_REG_DATA, 32'h0000_005A);
        bus_write(UART_REG_STATUS, 32'h0000_0000, 4'b0001);
        read_check("loopback_off", UART_REG_STATUS, 32'h0000_0005);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
